// File: rtl/buzzer_alarm_sched.sv
// buzzer_alarm_sched
//
// Shares one two-tone buzzer between four alarm requesters. A fixed-priority
// arbiter (requester 0 highest) picks a source in IDLE. The scheduler then plays
// id+1 beeps for it, alternating tone A and tone B and separated by silent gaps,
// and completes the pattern with a one-cycle ack.
//
// Optional feature macro: BUZZER_PREEMPT_EN
//   defined   : a higher-priority request aborts the running pattern (no ack)
//               and restarts the sequence for the new winner.
//   undefined : the running pattern always runs until it completes or is cancelled.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous reset, active-low
//   req[3:0]     level request per source
//   mute         forces tone_en low; timing is unaffected
//   grant[3:0]   one-hot, source currently served
//   ack[3:0]     one-cycle pulse on the served bit when its pattern completes
//   busy         high in BEEP, GAP and DONE
//   active_id    index of the served source
//   tone_en      enable to the downstream square-wave tone generator
//   half_period  half-period count for the tone generator
//
// Handshake: a requester raises req[i] and holds it high. ack[i] pulses for
// exactly one cycle when its pattern has finished. If req[i] drops while its
// pattern is in progress, the pattern is abandoned and no ack is issued. A req
// that is still high after ack replays the pattern, and this is legal.
//
// All outputs are registered.

module buzzer_alarm_sched #(
    parameter int CLK_HZ    = 10000000,
    parameter int TONE_A_HZ = 400,
    parameter int TONE_B_HZ = 300,
    parameter int BEEP_CYC  = 5000000,
    parameter int GAP_CYC   = 2500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic        mute,
    output logic [3:0]  grant,
    output logic [3:0]  ack,
    output logic        busy,
    output logic [1:0]  active_id,
    output logic        tone_en,
    output logic [15:0] half_period
);

    // Half-periods are truncated to 16 bits at elaboration time.
    localparam logic [15:0] HP_A      = 16'(CLK_HZ / TONE_A_HZ / 2);
    localparam logic [15:0] HP_B      = 16'(CLK_HZ / TONE_B_HZ / 2);
    localparam logic [23:0] BEEP_LAST = 24'(BEEP_CYC - 1);
    localparam logic [23:0] GAP_LAST  = 24'(GAP_CYC - 1);

    typedef enum logic [1:0] {IDLE, BEEP, GAP, DONE} state_t;

    state_t      state;
    logic [23:0] phase;   // cycles elapsed in the current BEEP or GAP
    logic [1:0]  k;       // index of the current beep within the pattern

    // Lowest-index active request.
    logic       win_found;
    logic [1:0] win_id;

    always_comb begin
        win_found = 1'b0;
        win_id    = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (req[i]) begin
                win_found = 1'b1;
                win_id    = 2'(i);
            end
        end
    end

    // The lowest-index winner is below active_id exactly when some request
    // with higher priority than the one being served is pending.
    logic preempt;
`ifdef BUZZER_PREEMPT_EN
    assign preempt = ((state == BEEP) || (state == GAP)) && win_found && (win_id < active_id);
`else
    assign preempt = 1'b0;
`endif

    logic start_now;
    assign start_now = ((state == IDLE) && win_found) || preempt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            phase       <= '0;
            k           <= '0;
            grant       <= '0;
            ack         <= '0;
            busy        <= 1'b0;
            active_id   <= '0;
            tone_en     <= 1'b0;
            half_period <= '0;
        end else begin
            ack <= '0;
            if (start_now) begin
                // A new pattern always starts from beep 0 on tone A with cleared counters.
                state       <= BEEP;
                phase       <= '0;
                k           <= '0;
                active_id   <= win_id;
                grant       <= 4'b0001 << win_id;
                busy        <= 1'b1;
                tone_en     <= ~mute;
                half_period <= HP_A;
            end else begin
                case (state)
                    IDLE: begin
                        // Nothing is requested. The outputs already hold their reset values.
                    end
                    BEEP, GAP: begin
                        if (!req[active_id]) begin
                            // The requester cancelled, so abandon the pattern without an ack.
                            state       <= IDLE;
                            phase       <= '0;
                            k           <= '0;
                            grant       <= '0;
                            busy        <= 1'b0;
                            active_id   <= '0;
                            tone_en     <= 1'b0;
                            half_period <= '0;
                        end else if (state == BEEP) begin
                            if (phase == BEEP_LAST) begin
                                phase   <= '0;
                                tone_en <= 1'b0;
                                if (k == active_id) begin
                                    state <= DONE;
                                    ack   <= 4'b0001 << active_id;
                                end else begin
                                    state <= GAP;
                                end
                            end else begin
                                phase   <= phase + 24'd1;
                                tone_en <= ~mute;
                            end
                        end else begin
                            if (phase == GAP_LAST) begin
                                phase       <= '0;
                                k           <= k + 2'd1;
                                state       <= BEEP;
                                tone_en     <= ~mute;
                                // The next beep index is k+1, so its parity is the inverse of k[0].
                                half_period <= k[0] ? HP_A : HP_B;
                            end else begin
                                phase <= phase + 24'd1;
                            end
                        end
                    end
                    DONE: begin
                        state       <= IDLE;
                        phase       <= '0;
                        k           <= '0;
                        grant       <= '0;
                        busy        <= 1'b0;
                        active_id   <= '0;
                        tone_en     <= 1'b0;
                        half_period <= '0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
